// File: rtl/dca_matrix_lsu_rbeat_collector.sv
// Matrix LSU read path: gathers the AXI R beats of one transaction into a row buffer and
// hands {row, txn info} to the row-alignment stage in descriptor order, with sticky response checks.
module dca_matrix_lsu_rbeat_collector #(
    parameter int BW_AXI_DATA          = 32,
    parameter int BW_MEMORY_ROW_BUFFER = 128,
    parameter int BW_BITADDR           = 8,
    parameter int BW_TXN_INFO          = BW_BITADDR + 10,
    parameter int TXN_FIFO_DEPTH       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            txn_valid,
    output logic                            txn_ready,
    input  logic [BW_TXN_INFO-1:0]          txn_info,
    input  logic                            rvalid,
    output logic                            rready,
    input  logic [BW_AXI_DATA-1:0]          rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rlast,
    output logic                            row_valid,
    input  logic                            row_ready,
    output logic [BW_MEMORY_ROW_BUFFER-1:0] row_data,
    output logic [BW_TXN_INFO-1:0]          row_info,
    input  logic                            err_clear,
    output logic [2:0]                      err_status
);

    localparam int NUM_BEATS = BW_MEMORY_ROW_BUFFER / BW_AXI_DATA;
    localparam int PTR_W     = $clog2(TXN_FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BW_TXN_INFO-1:0]          fifo_mem [TXN_FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                fifo_cnt;
    logic                            fifo_empty;
    logic                            push;
    logic                            pop;

    logic [BW_TXN_INFO-1:0]          cur_info;
    logic [7:0]                      cur_alen;
    logic [8:0]                      beat_cnt;
    logic [BW_MEMORY_ROW_BUFFER-1:0] row_buf;
    logic [BW_MEMORY_ROW_BUFFER-1:0] row_next;
    logic                            beat;
    logic                            beat_final;
    logic                            beat_in_range;

    logic                            err_rresp;
    logic                            err_rlast;
    logic                            err_overflow;
    logic                            set_rresp;
    logic                            set_rlast;
    logic                            set_overflow;

    // Descriptor FIFO: full refuses a push even when a pop happens in the same cycle.
    assign fifo_empty = (fifo_cnt == '0);
    assign txn_ready  = (fifo_cnt != CNT_W'(TXN_FIFO_DEPTH));
    assign push       = txn_valid & txn_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= txn_info;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Beat decode: only alen is interpreted, the rest of the descriptor is passed through.
    assign cur_alen      = cur_info[BW_BITADDR +: 8];
    assign beat          = rvalid & rready;
    assign beat_final    = (beat_cnt == {1'b0, cur_alen});
    assign beat_in_range = (beat_cnt < 9'(NUM_BEATS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rready    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                rready = 1'b1;
                if (rvalid && beat_final) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (row_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = COLLECT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane placement; beats past the last lane leave the row untouched.
    always_comb begin
        row_next = row_buf;
        for (int i = 0; i < NUM_BEATS; i++) begin
            if (beat_cnt == 9'(i)) begin
                row_next[i*BW_AXI_DATA +: BW_AXI_DATA] = rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            row_buf <= '0;
        end else if (beat) begin
            row_buf <= row_next;
        end
    end

    // Output row is captured only on the HOLD entry edge, so it stays stable while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_info <= '0;
            beat_cnt <= '0;
            row_data <= '0;
            row_info <= '0;
        end else begin
            if (pop) begin
                cur_info <= fifo_mem[rd_ptr];
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 9'd1;
                if (beat_final) begin
                    row_data <= row_next;
                    row_info <= cur_info;
                end
            end
        end
    end

    assign row_valid = (state == HOLD);

    // Sticky errors: a set event in the same cycle as err_clear wins.
    assign set_rresp    = beat & (rresp != 2'b00);
    assign set_rlast    = beat & (rlast != beat_final);
    assign set_overflow = beat & ~beat_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_rresp    <= 1'b0;
            err_rlast    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_rresp    <= (err_rresp    & ~err_clear) | set_rresp;
            err_rlast    <= (err_rlast    & ~err_clear) | set_rlast;
            err_overflow <= (err_overflow & ~err_clear) | set_overflow;
        end
    end

    assign err_status = {err_overflow, err_rlast, err_rresp};

endmodule
